// File: rtl/mem_wb_pkg.sv
// Shared types and defaults for the MEM->WB pipeline register.
// Control fields are carried in wb_ctrl_t; write_reg is sized for the widest supported register file.
package mem_wb_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int REG_AW_MAX  = 8;
    localparam int WB_ZERO_REG = 0;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  link;
        logic [REG_AW_MAX-1:0] write_reg;
    } wb_ctrl_t;

    // Writes to the hardwired zero register are dropped at capture time when gating is enabled.
    function automatic logic wb_gate_we(input logic we, input logic to_zero, input logic gate_en);
        return we & ~(gate_en & to_zero);
    endfunction

endpackage

// File: rtl/mem_wb_beat_reg.sv
// Generic valid+payload register: load sets valid and captures data, clear drops valid, else hold.
// Data is never cleared except by reset; load has priority over clear.
module mem_wb_beat_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end else if (clear_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Elastic MEM->WB register, 1-cycle latency, valid/ready with stall hold and flush; full throughput.
// MEM_WB_SKID_BUFFER_EN adds a second FIFO entry so in_ready comes straight from a flop.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int REG_AW        = REG_AW_DEF,
    parameter int ZERO_REG_GATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic              link_m,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [XLEN-1:0]   read_data_m,
    input  logic [XLEN-1:0]   alu_out_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write_w,
    output logic [REG_AW-1:0] write_reg_w,
    output logic [XLEN-1:0]   wb_data_w,
    output logic              mem_to_reg_w,
    output logic              link_w,
    output logic [XLEN-1:0]   read_data_w,
    output logic [XLEN-1:0]   alu_out_w,
    output logic [XLEN-1:0]   pc_plus4_w
);

    typedef struct packed {
        wb_ctrl_t          ctrl;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   alu_out;
        logic [XLEN-1:0]   pc_plus4;
    } beat_t;

    localparam int BW = $bits(beat_t);

    beat_t in_beat;
    beat_t main_src;
    beat_t main_beat;
    logic  main_vld;
    logic  main_load;
    logic  main_clear;
    logic  accept;
    logic  unused_wr_hi;

    always_comb begin
        in_beat                = '0;
        in_beat.ctrl.reg_write = wb_gate_we(reg_write_m,
                                            write_reg_m == REG_AW'(WB_ZERO_REG),
                                            ZERO_REG_GATE != 0);
        in_beat.ctrl.mem_to_reg = mem_to_reg_m;
        in_beat.ctrl.link       = link_m;
        in_beat.ctrl.write_reg  = REG_AW_MAX'(write_reg_m);
        in_beat.read_data       = read_data_m;
        in_beat.alu_out         = alu_out_m;
        in_beat.pc_plus4        = pc_plus4_m;
    end

`ifdef MEM_WB_SKID_BUFFER_EN
    beat_t skid_beat;
    logic  skid_vld;
    logic  skid_load;
    logic  skid_clear;
    logic  main_stall;

    // Skid only fills while main is stalled, so a full skid implies a full main.
    assign in_ready   = ~skid_vld;
    assign accept     = in_valid & in_ready;
    assign main_stall = main_vld & ~out_ready;

    assign main_load  = ~flush & ~main_stall & (skid_vld | accept);
    assign main_clear = flush | out_ready;
    assign main_src   = skid_vld ? skid_beat : in_beat;

    assign skid_load  = ~flush & main_stall & accept;
    assign skid_clear = flush | ~main_stall;

    mem_wb_beat_reg #(
        .W (BW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .dat_i   (in_beat),
        .vld_o   (skid_vld),
        .dat_o   (skid_beat)
    );
`else
    assign in_ready   = ~main_vld | out_ready;
    assign accept     = in_valid & in_ready;
    assign main_load  = accept & ~flush;
    assign main_clear = flush | out_ready;
    assign main_src   = in_beat;
`endif

    mem_wb_beat_reg #(
        .W (BW)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .dat_i   (main_src),
        .vld_o   (main_vld),
        .dat_o   (main_beat)
    );

    assign out_valid    = main_vld;
    assign reg_write_w  = main_beat.ctrl.reg_write & main_vld;
    assign write_reg_w  = main_beat.ctrl.write_reg[REG_AW-1:0];
    assign mem_to_reg_w = main_beat.ctrl.mem_to_reg;
    assign link_w       = main_beat.ctrl.link;
    assign read_data_w  = main_beat.read_data;
    assign alu_out_w    = main_beat.alu_out;
    assign pc_plus4_w   = main_beat.pc_plus4;

    // Link beats (JAL/JALR) write PC+4 regardless of mem_to_reg.
    assign wb_data_w = main_beat.ctrl.link       ? main_beat.pc_plus4  :
                       main_beat.ctrl.mem_to_reg ? main_beat.read_data :
                                                   main_beat.alu_out;

    // Upper write_reg bits are always zero-filled and never leave the block.
    assign unused_wr_hi = ^main_beat.ctrl.write_reg;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed plan items with literal expectations, then random traffic
// checked every cycle against a queue model of accepted beats.
module tb_mem_wb_pipe_reg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int GATE = 1;
`ifdef MEM_WB_SKID_BUFFER_EN
    localparam int CAP  = 2;
`else
    localparam int CAP  = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            reg_write_m;
    logic            mem_to_reg_m;
    logic            link_m;
    logic [AW-1:0]   write_reg_m;
    logic [XLEN-1:0] read_data_m;
    logic [XLEN-1:0] alu_out_m;
    logic [XLEN-1:0] pc_plus4_m;
    logic            out_valid;
    logic            out_ready;
    logic            reg_write_w;
    logic [AW-1:0]   write_reg_w;
    logic [XLEN-1:0] wb_data_w;
    logic            mem_to_reg_w;
    logic            link_w;
    logic [XLEN-1:0] read_data_w;
    logic [XLEN-1:0] alu_out_w;
    logic [XLEN-1:0] pc_plus4_w;

    mem_wb_pipe_reg #(
        .XLEN          (XLEN),
        .REG_AW        (AW),
        .ZERO_REG_GATE (GATE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .link_m       (link_m),
        .write_reg_m  (write_reg_m),
        .read_data_m  (read_data_m),
        .alu_out_m    (alu_out_m),
        .pc_plus4_m   (pc_plus4_m),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reg_write_w  (reg_write_w),
        .write_reg_w  (write_reg_w),
        .wb_data_w    (wb_data_w),
        .mem_to_reg_w (mem_to_reg_w),
        .link_w       (link_w),
        .read_data_w  (read_data_w),
        .alu_out_w    (alu_out_w),
        .pc_plus4_w   (pc_plus4_w)
    );

    typedef struct {
        logic            we;
        logic            m2r;
        logic            lnk;
        logic [AW-1:0]   wr;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] pc4;
    } tb_beat_t;

    tb_beat_t q[$];
    int       n_chk = 0;
    int       n_err = 0;
    bit       chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    endfunction

    function automatic logic [XLEN-1:0] exp_wb(input tb_beat_t b);
        return b.lnk ? b.pc4 : (b.m2r ? b.rd : b.alu);
    endfunction

    // Model: FIFO of accepted beats, capacity CAP; head is what the WB side sees.
    always @(posedge clk) begin
        tb_beat_t b;
        logic     acc;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && exp_ready();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                b.we  = reg_write_m && !(GATE != 0 && write_reg_m == '0);
                b.m2r = mem_to_reg_m;
                b.lnk = link_m;
                b.wr  = write_reg_m;
                b.rd  = read_data_m;
                b.alu = alu_out_m;
                b.pc4 = pc_plus4_m;
                q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(exp_ready()));
            if (q.size() > 0) begin
                check("reg_write_w", 64'(reg_write_w), 64'(q[0].we));
                check("write_reg_w", 64'(write_reg_w), 64'(q[0].wr));
                check("mem_to_reg_w", 64'(mem_to_reg_w), 64'(q[0].m2r));
                check("link_w", 64'(link_w), 64'(q[0].lnk));
                check("read_data_w", 64'(read_data_w), 64'(q[0].rd));
                check("alu_out_w", 64'(alu_out_w), 64'(q[0].alu));
                check("pc_plus4_w", 64'(pc_plus4_w), 64'(q[0].pc4));
                check("wb_data_w", 64'(wb_data_w), 64'(exp_wb(q[0])));
            end else begin
                check("reg_write_w_bubble", 64'(reg_write_w), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic lnk, input logic [AW-1:0] wr,
                         input logic [XLEN-1:0] rd, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] pc4);
        reg_write_m  = we;
        mem_to_reg_m = m2r;
        link_m       = lnk;
        write_reg_m  = wr;
        read_data_m  = rd;
        alu_out_m    = alu;
        pc_plus4_m   = pc4;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h1, 32'h2, 32'h3);

        // Reset with a beat offered
        step();
        chk_en = 1;
        step();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_reg_write_w", 64'(reg_write_w), 64'(0));
        check("rst_wb_data_w", 64'(wb_data_w), 64'(0));
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Streaming, one beat per cycle
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'(i * 16), 32'h0);
            step();
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_wb", 64'(wb_data_w), 64'(i * 16));
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 64'(out_valid), 64'(0));

        // Stall: A held while B is offered
        in_valid = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'hB0B, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold", 64'(wb_data_w), 64'hDEADBEEF);
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        if (CAP == 2) in_valid = 1'b0;
        step();
        check("stall_b_valid", 64'(out_valid), 64'(1));
        check("stall_b_wb", 64'(wb_data_w), 64'hB0B);
        in_valid = 1'b0;
        step();
        check("stall_drained", 64'(out_valid), 64'(0));

        // Flush kills stored D and incoming C
        in_valid = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'hD0D, 32'h0);
        step();
        check("flush_pre_valid", 64'(out_valid), 64'(1));
        flush = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 32'hC0C, 32'h0);
        step();
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_reg_write", 64'(reg_write_w), 64'(0));
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush_c_gone", 64'(out_valid), 64'(0));

        // r0 write suppression
        in_valid = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h77, 32'h0);
        step();
        check("r0_valid", 64'(out_valid), 64'(1));
        check("r0_reg_write", 64'(reg_write_w), 64'(0));

        // Link beats PC+4 over memory data
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h55, 32'h99, 32'h104);
        step();
        check("link_wb", 64'(wb_data_w), 64'h104);
        check("link_reg_write", 64'(reg_write_w), 64'(1));
        in_valid = 1'b0;
        step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            drive($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  32'($urandom), 32'($urandom), 32'($urandom));
            step();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
